// File: rtl/dmem_bank_sized.sv
// Synchronous sized data memory: byte/half/word access, fault flagging and
// a power-up fill sequencer that writes mem[i] = i*INIT_STEP after every reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | filling one word per clock, requests refused (req_ready = 0)
// ST_RUN  | accepting one request per clock, fixed one-cycle response
`timescale 1ns/1ps
module dmem_bank_sized #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 64,
  parameter int INIT_STEP = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_run;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-3:0] w_word;
  logic [IDX_W-1:0]  w_widx;
  logic [1:0]        w_lane;
  logic              w_fault;
  logic              w_accept;
  logic [31:0]       w_rd;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_wrep;
  logic [3:0]        w_be;
  logic [31:0]       w_merged;
  logic [31:0]       w_init;

  assign w_word   = req_addr[ADDR_W-1:2];
  assign w_widx   = w_word[IDX_W-1:0];
  assign w_lane   = req_addr[1:0];
  assign w_accept = req_valid & r_run;
  assign w_init   = 32'(r_idx) * 32'(INIT_STEP);

  assign w_fault = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]))
                 | (32'(w_word) >= 32'(DEPTH));

  // Out-of-range reads are harmless: the result is discarded on a fault.
  assign w_rd   = r_mem[w_widx];
  assign w_byte = w_rd[{w_lane, 3'b000} +: 8];
  assign w_half = w_rd[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = '0;
    case (req_size)
      2'b00:   w_load = {{24{~req_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~req_unsigned & w_half[15]}}, w_half};
      2'b10:   w_load = w_rd;
      default: w_load = '0;
    endcase
  end

  always_comb begin
    w_wrep = req_wdata;
    w_be   = 4'b0000;
    case (req_size)
      2'b00: begin
        w_wrep = {4{req_wdata[7:0]}};
        w_be   = 4'b0001 << w_lane;
      end
      2'b01: begin
        w_wrep = {2{req_wdata[15:0]}};
        w_be   = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_wrep = req_wdata;
        w_be   = 4'b1111;
      end
      default: begin
        w_wrep = req_wdata;
        w_be   = 4'b0000;
      end
    endcase
    w_merged = w_rd;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_merged[8*b +: 8] = w_wrep[8*b +: 8];
    end
  end

  // Array is not reset; the fill sequence owns its contents after reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_idx] <= w_init;
    end else if (w_accept & req_we & ~w_fault) begin
      r_mem[w_widx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_idx       <= '0;
      r_run       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_rsp_valid <= 1'b0;
          if (32'(r_idx) == 32'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_RUN: begin
          r_rsp_valid <= w_accept;
          if (w_accept) begin
            r_rsp_err   <= w_fault;
            r_rsp_rdata <= (w_fault | req_we) ? 32'h0 : w_load;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign req_ready = r_run;
  assign init_done = r_run;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_bank_sized.sv
// Directed bench for dmem_bank_sized: init timing, sized stores/loads,
// extension, faults, back-to-back traffic and mid-run reset.
`timescale 1ns/1ps
module tb_dmem_bank_sized;

  localparam int AW = 9;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  int tests = 0;
  int fails = 0;
  int cnt;

  dmem_bank_sized #(.ADDR_W(AW), .DEPTH(64), .INIT_STEP(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One accepted request; checks the response one edge later.
  task automatic xfer(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [AW-1:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".err"},   {31'd0, rsp_err},   {31'd0, exp_err});
    chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
  endtask

  task automatic wait_init(input string tag);
    cnt = 0;
    while (!req_ready && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, ".ready_low_cycles"}, cnt, 32'd64);
    chk({tag, ".init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #3;
    chk("rst.ready", {31'd0, req_ready}, 32'd0);
    chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.err",   {31'd0, rsp_err},   32'd0);
    chk("rst.done",  {31'd0, init_done}, 32'd0);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 9'h000;
    #2 rst_n = 1'b1;
    wait_init("init");
    xfer("ld0",   1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 1'b0, 32'd0);
    xfer("ld14",  1'b0, 2'b10, 1'b0, 9'h014, 32'h0, 1'b0, 32'd50);

    xfer("stw20", 1'b1, 2'b10, 1'b0, 9'h020, 32'hAABBCCDD, 1'b0, 32'h0);
    xfer("stb21", 1'b1, 2'b00, 1'b0, 9'h021, 32'hFFFFFF11, 1'b0, 32'h0);
    xfer("sth22", 1'b1, 2'b01, 1'b0, 9'h022, 32'hFFFF2233, 1'b0, 32'h0);
    xfer("ldw20", 1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 1'b0, 32'h223311DD);

    xfer("stext", 1'b1, 2'b10, 1'b0, 9'h020, 32'h80FF7F80, 1'b0, 32'h0);
    xfer("lbs20", 1'b0, 2'b00, 1'b0, 9'h020, 32'h0, 1'b0, 32'hFFFFFF80);
    xfer("lbu20", 1'b0, 2'b00, 1'b1, 9'h020, 32'h0, 1'b0, 32'h00000080);
    xfer("lbs21", 1'b0, 2'b00, 1'b0, 9'h021, 32'h0, 1'b0, 32'h0000007F);
    xfer("lbu23", 1'b0, 2'b00, 1'b1, 9'h023, 32'h0, 1'b0, 32'h00000080);
    xfer("lhs22", 1'b0, 2'b01, 1'b0, 9'h022, 32'h0, 1'b0, 32'hFFFF80FF);
    xfer("lhu22", 1'b0, 2'b01, 1'b1, 9'h022, 32'h0, 1'b0, 32'h000080FF);
    xfer("lhs20", 1'b0, 2'b01, 1'b0, 9'h020, 32'h0, 1'b0, 32'h00007F80);
    xfer("lwuns", 1'b0, 2'b10, 1'b1, 9'h020, 32'h0, 1'b0, 32'h80FF7F80);

    xfer("fh03",  1'b1, 2'b01, 1'b0, 9'h003, 32'hDEADBEEF, 1'b1, 32'h0);
    xfer("chk00", 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 1'b0, 32'd0);
    xfer("fw06",  1'b1, 2'b10, 1'b0, 9'h006, 32'hDEADBEEF, 1'b1, 32'h0);
    xfer("chk04", 1'b0, 2'b10, 1'b0, 9'h004, 32'h0, 1'b0, 32'd10);
    xfer("fs11",  1'b1, 2'b11, 1'b0, 9'h00C, 32'hDEADBEEF, 1'b1, 32'h0);
    xfer("chk0c", 1'b0, 2'b10, 1'b0, 9'h00C, 32'h0, 1'b0, 32'd30);
    xfer("fl11",  1'b0, 2'b11, 1'b0, 9'h010, 32'h0, 1'b1, 32'h0);
    xfer("foob",  1'b0, 2'b10, 1'b0, 9'h100, 32'h0, 1'b1, 32'h0);
    xfer("fhl05", 1'b0, 2'b01, 1'b1, 9'h005, 32'h0, 1'b1, 32'h0);
    xfer("last",  1'b0, 2'b10, 1'b0, 9'h0FC, 32'h0, 1'b0, 32'd630);

    xfer("b2b.st", 1'b1, 2'b10, 1'b0, 9'h008, 32'h12345678, 1'b0, 32'h0);
    xfer("b2b.ld", 1'b0, 2'b10, 1'b0, 9'h008, 32'h0, 1'b0, 32'h12345678);
    @(posedge clk);
    #1;
    chk("idle.valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle.hold",  rsp_rdata, 32'h12345678);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.ready", {31'd0, req_ready}, 32'd0);
    chk("mrst.rdata", rsp_rdata, 32'd0);
    chk("mrst.done",  {31'd0, init_done}, 32'd0);
    chk("mrst.err",   {31'd0, rsp_err},   32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 9'h008;
    #1 rst_n = 1'b1;
    wait_init("reinit");
    xfer("re08", 1'b0, 2'b10, 1'b0, 9'h008, 32'h0, 1'b0, 32'd20);
    xfer("re20", 1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 1'b0, 32'd80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
